i2c_slave_regfile: RTL and testbench

//  Parametrised I2C target (slave) with an internal NUM_REGS x 8 register file.

---
 rtl/i2c_slave_regfile_pkg.sv | 21 ++
 rtl/i2c_slave_regfile_in_filter.sv | 57 +++++
 rtl/i2c_slave_regfile.sv | 259 +++++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_regfile_pkg.sv
// i2c_pkg: shared types and constants for the I2C target register file.
//   i2c_state_t : protocol FSM states
//   I2C_ACK     : SDA level of an acknowledge bit
//   I2C_NACK    : SDA level of a not-acknowledge bit
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        WDATA,
        RDATA,
        RACK,
        IGNORE
    } i2c_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_slave_regfile_in_filter.sv
// i2c_in_filter: synchroniser plus stability filter for one I2C pad input.
//   clk, rst_n : system clock, asynchronous active-low reset
//   in_i       : raw pad input
//   filt_o     : filtered level, lags in_i by SYNC_STAGES+FILTER_LEN clk
//   rise_o     : 1-clk pulse, asserted in the cycle filt_o goes 0->1 on the next edge
//   fall_o     : 1-clk pulse, asserted in the cycle filt_o goes 1->0 on the next edge
module i2c_in_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3,
    parameter logic        RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_i,
    output logic filt_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   sync_out;
    logic                   differ;
    logic                   upd;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // The counter runs while the synchronised input disagrees with the
    // filtered level; FILTER_LEN consecutive disagreeing clocks flip it.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_i};
        differ = (sync_out != filt_q);
        upd    = differ && (cnt_q == CNT_W'(FILTER_LEN - 1));
        cnt_d  = (differ && !upd) ? cnt_q + CNT_W'(1) : '0;
        filt_d = upd ? sync_out : filt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            cnt_q  <= '0;
            filt_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt_o = filt_q;
    assign rise_o = upd &  sync_out;
    assign fall_o = upd & ~sync_out;

endmodule

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target with a NUM_REGS x 8 register file and host port.
//   clk, rst_n   : system clock (>=16x SCL), asynchronous active-low reset
//   scl_i, sda_i : I2C pad inputs
//   sda_oe       : 1 pulls SDA low, 0 releases it
//   host_we/host_addr/host_wdata : host write port
//   host_rdata   : combinational reg[host_addr]
//   i2c_wr_vld/i2c_wr_addr/i2c_wr_data : 1-clk notification of an I2C commit
//   busy         : set on an address-matched START, cleared by STOP
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = 7'h51,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3,
    localparam int unsigned PTR_W      = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    input  logic             host_we,
    input  logic [PTR_W-1:0] host_addr,
    input  logic [7:0]       host_wdata,
    output logic [7:0]       host_rdata,
    output logic             i2c_wr_vld,
    output logic [PTR_W-1:0] i2c_wr_addr,
    output logic [7:0]       i2c_wr_data,
    output logic             busy
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_in_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .RST_VAL(1'b1)) u_scl_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_i   (scl_i),
        .filt_o (scl_f),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_in_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .RST_VAL(1'b1)) u_sda_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_i   (sda_i),
        .filt_o (sda_f),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    i2c_state_t       state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;     // inside the ACK slot of a PTR/WDATA byte
    logic             mack_q, mack_d;   // master's acknowledge bit during RACK
    logic             rw_q, rw_d;
    logic             wr_vld_q, wr_vld_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic [7:0]       regs_q [NUM_REGS];
    logic [7:0]       regs_d [NUM_REGS];

    logic             start_c, stop_c;
    logic             rx_bit, byte_end;
    logic             commit;
    logic [PTR_W-1:0] ptr_inc;

    assign start_c  = sda_fall & scl_f;
    assign stop_c   = sda_rise & scl_f;
    assign rx_bit   = scl_rise & ~ack_q & (bit_cnt_q < 4'd8);
    assign byte_end = scl_fall & ~ack_q & (bit_cnt_q == 4'd8);
    assign ptr_inc  = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_W'(1);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        ack_d     = ack_q;
        mack_d    = mack_q;
        rw_d      = rw_q;
        wr_vld_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        commit    = 1'b0;

        if (stop_c) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            sda_oe_d  = 1'b0;
            ack_d     = 1'b0;
            bit_cnt_d = '0;
        end else if (start_c) begin
            state_d   = ADDR;
            sda_oe_d  = 1'b0;
            ack_d     = 1'b0;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                ADDR: begin
                    if (rx_bit) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (byte_end) begin
                        if (shift_q[7:1] == DEV_ADDR) begin
                            state_d  = ADDR_ACK;
                            rw_d     = shift_q[0];
                            busy_d   = 1'b1;
                            sda_oe_d = ~I2C_ACK;
                        end else begin
                            state_d  = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            state_d  = RDATA;
                            shift_d  = regs_q[ptr_q];
                            sda_oe_d = ~regs_q[ptr_q][7];
                        end else begin
                            state_d  = PTR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                PTR: begin
                    if (rx_bit) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (byte_end) begin
                        if ({1'b0, shift_q} < 9'(NUM_REGS)) begin
                            state_d  = WDATA;
                            ptr_d    = PTR_W'(shift_q);
                            sda_oe_d = ~I2C_ACK;
                            ack_d    = 1'b1;
                        end else begin
                            state_d  = IGNORE;
                        end
                    end
                end
                WDATA: begin
                    if (scl_fall && ack_q) begin
                        sda_oe_d  = 1'b0;
                        ack_d     = 1'b0;
                        bit_cnt_d = '0;
                    end else if (rx_bit) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (byte_end) begin
                        commit    = 1'b1;
                        wr_vld_d  = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = shift_q;
                        ptr_d     = ptr_inc;
                        sda_oe_d  = ~I2C_ACK;
                        ack_d     = 1'b1;
                    end
                end
                RDATA: begin
                    // MSB went out when the byte was loaded; each following
                    // SCL fall presents the next bit, the eighth releases SDA.
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d  = RACK;
                        sda_oe_d = 1'b0;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        mack_d = sda_f;
                    end else if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (mack_q == I2C_ACK) begin
                            state_d  = RDATA;
                            ptr_d    = ptr_inc;
                            shift_d  = regs_q[ptr_inc];
                            sda_oe_d = ~regs_q[ptr_inc][7];
                        end else begin
                            state_d  = IGNORE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                IDLE, IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // I2C commit is applied after the host write so it wins on a collision.
    always_comb begin
        regs_d = regs_q;
        if (host_we) begin
            regs_d[host_addr] = host_wdata;
        end
        if (commit) begin
            regs_d[ptr_q] = shift_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            mack_q    <= I2C_NACK;
            rw_q      <= 1'b0;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            regs_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            mack_q    <= mack_d;
            rw_q      <= rw_d;
            wr_vld_q  <= wr_vld_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            regs_q    <= regs_d;
        end
    end

    assign sda_oe      = sda_oe_q;
    assign busy        = busy_q;
    assign i2c_wr_vld  = wr_vld_q;
    assign i2c_wr_addr = wr_addr_q;
    assign i2c_wr_data = wr_data_q;
    assign host_rdata  = regs_q[host_addr];

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile: bus-functional I2C master driving i2c_slave_regfile.
// Expected commits and read bytes are queued when stimulus is issued and
// compared when the DUT produces them.
module tb_i2c_slave_regfile;

    localparam int unsigned NREG  = 16;
    localparam int unsigned PW    = 4;
    localparam int unsigned HALF  = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          scl;
    logic          sda_m;
    logic          sda_oe;
    logic          sda_line;
    logic          host_we;
    logic [PW-1:0] host_addr;
    logic [7:0]    host_wdata;
    logic [7:0]    host_rdata;
    logic          i2c_wr_vld;
    logic [PW-1:0] i2c_wr_addr;
    logic [7:0]    i2c_wr_data;
    logic          busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [7:0]  mdl [NREG];
    logic [15:0] exp_wr_q [$];
    logic [7:0]  exp_rd_q [$];

    logic oe_clr = 1'b0;
    logic oe_seen;

    always #5 clk = ~clk;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_regfile #(
        .DEV_ADDR    (7'h51),
        .NUM_REGS    (NREG),
        .SYNC_STAGES (2),
        .FILTER_LEN  (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl_i       (scl),
        .sda_i       (sda_line),
        .sda_oe      (sda_oe),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .i2c_wr_vld  (i2c_wr_vld),
        .i2c_wr_addr (i2c_wr_addr),
        .i2c_wr_data (i2c_wr_data),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (oe_clr)      oe_seen <= 1'b0;
        else if (sda_oe) oe_seen <= 1'b1;
    end

    always @(negedge clk) begin
        if (i2c_wr_vld) begin
            if (exp_wr_q.size() == 0) begin
                check("wr_unexpected", {16'h0, 8'(i2c_wr_addr), i2c_wr_data}, 32'hFFFF_FFFF);
            end else begin
                check("wr_commit", {16'h0, 8'(i2c_wr_addr), i2c_wr_data}, {16'h0, exp_wr_q.pop_front()});
            end
        end
    end

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic i2c_start();
        scl = 1'b1; sda_m = 1'b1;
        clk_wait(HALF);
        sda_m = 1'b0;
        clk_wait(HALF);
        scl = 1'b0;
    endtask

    task automatic i2c_rstart();
        clk_wait(4);
        sda_m = 1'b1;
        clk_wait(HALF - 4);
        scl = 1'b1;
        clk_wait(HALF);
        sda_m = 1'b0;
        clk_wait(HALF);
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        clk_wait(4);
        sda_m = 1'b0;
        clk_wait(HALF - 4);
        scl = 1'b1;
        clk_wait(HALF);
        sda_m = 1'b1;
        clk_wait(HALF);
    endtask

    task automatic i2c_bit(input logic b, output logic s);
        clk_wait(4);
        sda_m = b;
        clk_wait(HALF - 4);
        scl = 1'b1;
        clk_wait(HALF / 2);
        s = sda_line;
        clk_wait(HALF / 2);
        scl = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], s);
        i2c_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, s);
            d[i] = s;
        end
        i2c_bit(mack, s);
    endtask

    task automatic host_write(input logic [PW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
        mdl[a] = d;
    endtask

    task automatic chk_reg(input int unsigned i);
        @(negedge clk);
        host_addr = PW'(i);
        #1;
        check($sformatf("reg%0d", i), {24'h0, host_rdata}, {24'h0, mdl[i]});
    endtask

    task automatic chk_read(input string tag, input logic [7:0] got);
        logic [7:0] e;
        if (exp_rd_q.size() == 0) begin
            check({tag, "_unexpected"}, {24'h0, got}, 32'hFFFF_FFFF);
        end else begin
            e = exp_rd_q.pop_front();
            check(tag, {24'h0, got}, {24'h0, e});
        end
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;

        rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
        host_we = 1'b0; host_addr = '0; host_wdata = '0;
        for (int i = 0; i < NREG; i++) mdl[i] = 8'h00;
        clk_wait(5);
        @(negedge clk);
        check("rst_sda_oe",  {31'h0, sda_oe}, 32'h0);
        check("rst_busy",    {31'h0, busy}, 32'h0);
        check("rst_wr_vld",  {31'h0, i2c_wr_vld}, 32'h0);
        check("rst_wr_addr", {28'h0, i2c_wr_addr}, 32'h0);
        check("rst_wr_data", {24'h0, i2c_wr_data}, 32'h0);
        rst_n = 1'b1;
        clk_wait(10);
        for (int i = 0; i < NREG; i++) chk_reg(i);

        // 1: multi-byte write with auto-increment
        i2c_start();
        wr_byte(8'hA2, ack); check("t1_addr_ack", {31'h0, ack}, 32'h0);
        check("t1_busy", {31'h0, busy}, 32'h1);
        wr_byte(8'h03, ack); check("t1_ptr_ack", {31'h0, ack}, 32'h0);
        exp_wr_q.push_back({8'd3, 8'h11}); mdl[3] = 8'h11;
        wr_byte(8'h11, ack); check("t1_d0_ack", {31'h0, ack}, 32'h0);
        exp_wr_q.push_back({8'd4, 8'h22}); mdl[4] = 8'h22;
        wr_byte(8'h22, ack); check("t1_d1_ack", {31'h0, ack}, 32'h0);
        i2c_stop();
        check("t1_busy_after", {31'h0, busy}, 32'h0);
        check("t1_commits_done", exp_wr_q.size(), 32'h0);
        chk_reg(3); chk_reg(4);

        // 2: pointer write, repeated START, read; host write during RDATA
        host_write(4'd5, 8'hCA);
        i2c_start();
        wr_byte(8'hA2, ack); check("t2_addr_ack", {31'h0, ack}, 32'h0);
        wr_byte(8'h05, ack); check("t2_ptr_ack", {31'h0, ack}, 32'h0);
        i2c_rstart();
        exp_rd_q.push_back(mdl[5]);
        wr_byte(8'hA3, ack); check("t2_raddr_ack", {31'h0, ack}, 32'h0);
        clk_wait(8);
        host_write(4'd5, 8'h33);
        rd_byte(1'b1, d);
        chk_read("t2_rdata", d);
        check("t2_busy_before_stop", {31'h0, busy}, 32'h1);
        i2c_stop();
        check("t2_busy_after", {31'h0, busy}, 32'h0);
        chk_reg(5);

        // 3: wrong device address, SDA must never be driven
        @(negedge clk); oe_clr = 1'b1;
        @(negedge clk); oe_clr = 1'b0;
        i2c_start();
        wr_byte(8'hB0, ack); check("t3_addr_nack", {31'h0, ack}, 32'h1);
        wr_byte(8'h03, ack); check("t3_d0_nack", {31'h0, ack}, 32'h1);
        wr_byte(8'h99, ack); check("t3_d1_nack", {31'h0, ack}, 32'h1);
        i2c_stop();
        @(negedge clk);
        check("t3_oe_never", {31'h0, oe_seen}, 32'h0);
        check("t3_busy", {31'h0, busy}, 32'h0);
        chk_reg(3);

        // 4: out-of-range pointer
        i2c_start();
        wr_byte(8'hA2, ack); check("t4_addr_ack", {31'h0, ack}, 32'h0);
        wr_byte(8'h10, ack); check("t4_ptr_nack", {31'h0, ack}, 32'h1);
        wr_byte(8'h55, ack); check("t4_data_nack", {31'h0, ack}, 32'h1);
        i2c_stop();
        for (int i = 0; i < NREG; i++) chk_reg(i);

        // 5: pointer wrap on write and on read
        i2c_start();
        wr_byte(8'hA2, ack); check("t5_addr_ack", {31'h0, ack}, 32'h0);
        wr_byte(8'h0F, ack); check("t5_ptr_ack", {31'h0, ack}, 32'h0);
        exp_wr_q.push_back({8'd15, 8'hAA}); mdl[15] = 8'hAA;
        wr_byte(8'hAA, ack); check("t5_d0_ack", {31'h0, ack}, 32'h0);
        exp_wr_q.push_back({8'd0, 8'hBB}); mdl[0] = 8'hBB;
        wr_byte(8'hBB, ack); check("t5_d1_ack", {31'h0, ack}, 32'h0);
        i2c_stop();
        chk_reg(15); chk_reg(0);
        i2c_start();
        wr_byte(8'hA2, ack);
        wr_byte(8'h0F, ack);
        i2c_rstart();
        exp_rd_q.push_back(mdl[15]);
        exp_rd_q.push_back(mdl[0]);
        wr_byte(8'hA3, ack); check("t5_raddr_ack", {31'h0, ack}, 32'h0);
        rd_byte(1'b0, d); chk_read("t5_rd0", d);
        rd_byte(1'b1, d); chk_read("t5_rd1", d);
        i2c_stop();

        // 6a: single-clk SCL glitch is filtered out
        i2c_start();
        wr_byte(8'hA2, ack);
        clk_wait(3);
        @(negedge clk); scl = 1'b1;
        @(negedge clk); scl = 1'b0;
        wr_byte(8'h06, ack); check("t6_glitch_ptr_ack", {31'h0, ack}, 32'h0);
        exp_wr_q.push_back({8'd6, 8'h77}); mdl[6] = 8'h77;
        wr_byte(8'h77, ack); check("t6_glitch_d_ack", {31'h0, ack}, 32'h0);
        i2c_stop();
        chk_reg(6);

        // 6b: STOP after four data bits discards the partial byte
        i2c_start();
        wr_byte(8'hA2, ack);
        wr_byte(8'h07, ack); check("t6_part_ptr_ack", {31'h0, ack}, 32'h0);
        for (int i = 0; i < 4; i++) i2c_bit(1'b1, s);
        i2c_stop();
        check("t6_part_busy", {31'h0, busy}, 32'h0);
        chk_reg(7);

        // 6c: reset mid-read releases SDA immediately
        host_write(4'd9, 8'h00);
        i2c_start();
        wr_byte(8'hA2, ack);
        wr_byte(8'h09, ack);
        i2c_rstart();
        wr_byte(8'hA3, ack);
        clk_wait(8);
        @(negedge clk);
        check("t6_oe_driving", {31'h0, sda_oe}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_oe", {31'h0, sda_oe}, 32'h0);
        check("t6_rst_busy", {31'h0, busy}, 32'h0);
        scl = 1'b1; sda_m = 1'b1;
        for (int i = 0; i < NREG; i++) mdl[i] = 8'h00;
        clk_wait(4);
        rst_n = 1'b1;
        clk_wait(20);
        chk_reg(3); chk_reg(6); chk_reg(15);

        check("wr_queue_empty", exp_wr_q.size(), 32'h0);
        check("rd_queue_empty", exp_rd_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
